// File: rtl/nav_pkg.sv
// rtl/nav_pkg.sv - shared state type and default speed constants for nav_cmd
package nav_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDNG    = 2'd1,
    RAMP_UP = 2'd2,
    RAMP_DN = 2'd3
  } nav_state_t;

  localparam logic [10:0] MAX_SPD_DEF = 11'h2A0;
  localparam logic [10:0] SPD_INC_DEF = 11'h010;

endpackage

// File: rtl/spd_ramp.sv
// rtl/spd_ramp.sv - forward-speed register with saturating ramp up / clamped ramp down
module spd_ramp
  import nav_pkg::*;
#(
  parameter logic [10:0] MAX_SPD = MAX_SPD_DEF,
  parameter logic [10:0] SPD_INC = SPD_INC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        dec,
  input  logic        clr,
  output logic [10:0] frwrd_spd,
  output logic        spd_zero
);

  localparam logic [11:0] INC_12 = {1'b0, SPD_INC};
  localparam logic [11:0] DEC_12 = {SPD_INC, 1'b0};
  localparam logic [11:0] MAX_12 = {1'b0, MAX_SPD};

  logic [11:0] up_sum;
  logic [10:0] up_val;
  logic [10:0] dn_val;

  // Sum carried at 12 bits so the clamp sees true overshoot, never a wrap.
  always_comb begin
    up_sum = {1'b0, frwrd_spd} + INC_12;
    up_val = (up_sum > MAX_12) ? MAX_SPD : up_sum[10:0];
    dn_val = ({1'b0, frwrd_spd} <= DEC_12) ? 11'h000 : (frwrd_spd - DEC_12[10:0]);
  end

  // Flags that the next decrement lands on zero, so the FSM can leave in the same cycle.
  assign spd_zero = (dn_val == 11'h000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    frwrd_spd <= 11'h000;
    else if (clr)  frwrd_spd <= 11'h000;
    else if (inc)  frwrd_spd <= up_val;
    else if (dec)  frwrd_spd <= dn_val;
  end

endmodule

// File: rtl/nav_cmd.sv
// rtl/nav_cmd.sv - navigation command sequencer feeding heading and speed to the PID
module nav_cmd
  import nav_pkg::*;
#(
  parameter logic [10:0] MAX_SPD = MAX_SPD_DEF,
  parameter logic [10:0] SPD_INC = SPD_INC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_hdng,
  input  logic [11:0] new_hdng,
  input  logic        strt_mv,
  input  logic        mv_stp,
  input  logic        estop,
  input  logic        hdng_vld,
  input  logic        at_hdng,
  output logic        moving,
  output logic [11:0] dsrd_hdng,
  output logic [10:0] frwrd_spd,
  output logic        mv_cmplt
);

  nav_state_t state, nxt;
  logic       guard_seen;
  logic       spd_zero;
  logic       inc, dec, clr;
  logic       mv_cmplt_d;

  spd_ramp #(.MAX_SPD(MAX_SPD), .SPD_INC(SPD_INC)) u_spd_ramp (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (inc),
    .dec      (dec),
    .clr      (clr),
    .frwrd_spd(frwrd_spd),
    .spd_zero (spd_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (estop) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (strt_hdng) nxt = HDNG;
                 else if (strt_mv) nxt = RAMP_UP;
        HDNG:    if (hdng_vld && guard_seen && at_hdng) nxt = IDLE;
        RAMP_UP: if (mv_stp) nxt = RAMP_DN;
        RAMP_DN: if (hdng_vld && spd_zero) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  // A stop request takes precedence over the increment of the same strobe.
  always_comb begin
    inc        = (state == RAMP_UP) && hdng_vld && !mv_stp && !estop;
    dec        = (state == RAMP_DN) && hdng_vld && !estop;
    clr        = estop;
    mv_cmplt_d = !estop && (state != IDLE) && (nxt == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      moving     <= 1'b0;
      mv_cmplt   <= 1'b0;
      dsrd_hdng  <= 12'h000;
      guard_seen <= 1'b0;
    end else begin
      moving   <= (nxt != IDLE);
      mv_cmplt <= mv_cmplt_d;
      if (!estop && (state == IDLE) && strt_hdng)
        dsrd_hdng <= new_hdng;
      // The first strobe after entering HDNG reflects stale PID data and only arms the check.
      if (state == IDLE)
        guard_seen <= 1'b0;
      else if ((state == HDNG) && hdng_vld)
        guard_seen <= 1'b1;
    end
  end

endmodule

// File: doc/nav_cmd.md
# nav_cmd

Navigation command sequencer that sits directly upstream of the heading PID controller. It accepts heading-change and move commands from the maze/command layer and drives the PID inputs `dsrd_hdng`, `frwrd_spd` and `moving`. It closes heading commands using the PID's `at_hdng` flag and ramps forward speed up and down in step with `hdng_vld`, so the PID never sees a speed step.

## Interface
- `MAX_SPD`, default 11'h2A0: cruise forward-speed ceiling.
- `SPD_INC`, default 11'h010: ramp-up increment per `hdng_vld`; ramp-down uses 2×`SPD_INC`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low; clock `clk`.
- `strt_hdng`  in  1  one-cycle pulse: begin heading change to `new_hdng`.
- `new_hdng`  in  12  signed target heading, sampled when `strt_hdng` is accepted.
- `strt_mv`  in  1  one-cycle pulse: begin forward move on current heading.
- `mv_stp`  in  1  one-cycle pulse: end forward move (ramp down).
- `estop`  in  1  level: emergency stop, highest priority.
- `hdng_vld`  in  1  new-heading-sample strobe (same strobe the PID uses).
- `at_hdng`  in  1  from PID: heading error within tolerance.
- `moving`  out  1  to PID: enables integrator and wheel speeds.
- `dsrd_hdng`  out  12  signed, to PID.
- `frwrd_spd`  out  11  unsigned, to PID.
- `mv_cmplt`  out  1  one-cycle pulse when a command finishes normally.

## Operation
- States: IDLE, HDNG, RAMP_UP, RAMP_DN.
- IDLE: `moving`=0, `frwrd_spd`=0.
  - `strt_hdng` → HDNG; load `dsrd_hdng`←`new_hdng`.
  - Else `strt_mv` → RAMP_UP.
  - If both pulse in the same cycle, the heading command wins and `strt_mv` is dropped.
- HDNG: `moving`=1, `frwrd_spd`=0.
  - The first `hdng_vld` after entry is a guard sample: `at_hdng` is ignored because of PID pipeline latency.
  - On any later `hdng_vld` with `at_hdng`=1 → IDLE and pulse `mv_cmplt`.
- RAMP_UP: `moving`=1.
  - Each `hdng_vld`: `frwrd_spd` += `SPD_INC`, saturating at `MAX_SPD`. No overshoot; the sum is computed at 12 bits and clamped.
  - `mv_stp` → RAMP_DN. The speed reached is kept.
- RAMP_DN: `moving`=1.
  - Each `hdng_vld`: `frwrd_spd` -= 2×`SPD_INC`, clamped at 0.
  - When `frwrd_spd` is 0 at a `hdng_vld` (after the decrement) → IDLE and pulse `mv_cmplt`.
- `mv_stp` outside RAMP_UP is ignored. `strt_hdng`/`strt_mv` outside IDLE are ignored: no queuing, and `dsrd_hdng` is unchanged.
- `estop`=1 in any state:
  - Next cycle state=IDLE, `frwrd_spd`=0, `moving`=0.
  - No `mv_cmplt`.
  - `dsrd_hdng` is retained.
  - While `estop` is held, all commands are ignored.
- `dsrd_hdng` changes only on an accepted `strt_hdng`.

## Timing
- Reset values: state IDLE, `moving`=0, `dsrd_hdng`=12'h000, `frwrd_spd`=11'h000, `mv_cmplt`=0.
- All outputs are registered; there is no combinational input→output path.
- Command accept → `moving`=1 on the next rising edge (1-cycle latency).
- `frwrd_spd` updates on the edge after the `hdng_vld` cycle.
- `mv_cmplt` is high for exactly the one cycle in which the state first reads IDLE.
- `hdng_vld` coinciding with `mv_stp` in RAMP_UP: the transition wins and no increment occurs that cycle.
- `estop` coinciding with anything: `estop` wins.
- Asynchronous reset mid-ramp: all outputs return to reset values immediately.

## Structure
- `nav_pkg`: state enum type `nav_state_t` (IDLE, HDNG, RAMP_UP, RAMP_DN) and the default speed constants.
- One sub-module, `spd_ramp`:
  - Holds the `frwrd_spd` register and the saturating add/subtract.
  - Controls: inc, dec, clr.
  - Flag: `spd_zero`.
- The FSM, guard-sample flag and `dsrd_hdng` register live in `nav_cmd`.

## Test plan
- Reset, then `strt_hdng` with `new_hdng`=12'h3FF → `dsrd_hdng`=12'h3FF and `moving`=1 next cycle. `at_hdng`=1 on the first `hdng_vld` is ignored. `at_hdng`=1 on the second `hdng_vld` → `mv_cmplt` pulse, `moving`=0.
- `strt_mv`, 50 `hdng_vld` pulses → `frwrd_spd` reaches 11'h2A0 at pulse 42 and holds there.
- From cruise 11'h2A0: `mv_stp`, then 21 `hdng_vld` pulses → `frwrd_spd`=0 and a single `mv_cmplt`. Pulse 20 leaves 11'h020.
- `strt_hdng` and `strt_mv` in the same cycle → HDNG entered, no ramp afterwards. `strt_mv` during HDNG → no effect.
- `estop` during RAMP_UP at 11'h100 → next cycle `frwrd_spd`=0, `moving`=0, no `mv_cmplt`, `dsrd_hdng` unchanged.
- Assert `rst_n` low mid-RAMP_DN → all outputs at reset values without waiting for a clock edge.
